// File: rtl/vga_sync_gen_pkg.sv
// Shared types for the VGA timing generator: counter width, output bundle, window decode.
// Pure declarations; no latency or flow control involved.
package vga_sync_gen_pkg;

  localparam int CNT_W = 11;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    cnt_t x_px;
    cnt_t y_px;
    logic activevideo;
  } vga_out_t;

  // True when lo <= val < hi_excl.
  function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi_excl);
    return (val >= lo) && (val < hi_excl);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Beam-timing bundle from the sync generator to a pixel renderer, all on px_clk.
// Free-running stream with no backpressure; activevideo qualifies each pixel.
interface vga_sync_gen_if;
  import vga_sync_gen_pkg::*;

  logic hsync;
  logic vsync;
  cnt_t x_px;
  cnt_t y_px;
  logic activevideo;

  modport master (
    output hsync,
    output vsync,
    output x_px,
    output y_px,
    output activevideo
  );

  modport slave (
    input hsync,
    input vsync,
    input x_px,
    input y_px,
    input activevideo
  );

endinterface

// File: rtl/vga_pll.sv
// Pixel clock source: iCE40 PLL from the 12 MHz reference, or a straight clock pass-through.
// Combinational clock path; lock reports when px_clk is usable, no flow control.
module vga_pll #(
  parameter int FDivider   = 83,
  parameter int QDivider   = 5,
  parameter bit SIM_BYPASS = 1'b0
) (
  input  logic clk,
  output logic px_clk,
  output logic lock
);

  if (FDivider < 0 || FDivider > 127) begin : g_bad_divf
    $error("vga_pll: FDivider does not fit the 7-bit DIVF field");
  end

  if (QDivider < 1 || QDivider > 6) begin : g_bad_divq
    $error("vga_pll: QDivider outside the usable DIVQ range 1..6");
  end

  if (SIM_BYPASS) begin : g_bypass
    assign px_clk = clk;
    assign lock   = 1'b1;
  end else begin : g_pll
`ifdef SYNTHESIS
    SB_PLL40_CORE #(
      .FEEDBACK_PATH ("SIMPLE"),
      .DIVR          (4'b0000),
      .DIVF          (7'(FDivider)),
      .DIVQ          (3'(QDivider)),
      .FILTER_RANGE  (3'b001)
    ) u_pll (
      .REFERENCECLK (clk),
      .PLLOUTCORE   (px_clk),
      .PLLOUTGLOBAL (),
      .LOCK         (lock),
      .RESETB       (1'b1),
      .BYPASS       (1'b0)
    );
`else
    // No PLL model exists outside synthesis, so behave as an always-locked pass-through.
    assign px_clk = clk;
    assign lock   = 1'b1;
`endif
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA beam timing: free-running h/v counters decoded into sync, position and active-video.
// Outputs lag the counters by one px_clk; no backpressure, the raster never stalls.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int FDivider     = 83,
  parameter int QDivider     = 5,
  parameter int activeHvideo = 640,
  parameter int activeVvideo = 480,
  parameter int hfp          = 24,
  parameter int hpulse       = 40,
  parameter int hbp          = 128,
  parameter int vfp          = 9,
  parameter int vpulse       = 2,
  parameter int vbp          = 29,
  parameter bit SYNC_POL     = 1'b0,
  parameter bit SIM_BYPASS   = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          px_clk,
  vga_sync_gen_if.master vga
);

  localparam int HTOT     = activeHvideo + hfp + hpulse + hbp;
  localparam int VTOT     = activeVvideo + vfp + vpulse + vbp;
  localparam int HS_START = activeHvideo + hfp;
  localparam int VS_START = activeVvideo + vfp;

  localparam logic SYNC_ACT  = SYNC_POL;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  if (HTOT > 2047 || VTOT > 2047) begin : g_bad_totals
    $error("vga_sync_gen: line or frame total exceeds the 11-bit counter range");
  end

  logic pll_lock;
  logic rst_i;

  vga_pll #(
    .FDivider   (FDivider),
    .QDivider   (QDivider),
    .SIM_BYPASS (SIM_BYPASS)
  ) u_pll (
    .clk    (clk),
    .px_clk (px_clk),
    .lock   (pll_lock)
  );

  // Hold the raster in reset until the pixel clock is trustworthy.
  assign rst_i = reset | ~pll_lock;

  cnt_t     hc_q;
  cnt_t     hc_d;
  cnt_t     vc_q;
  cnt_t     vc_d;
  vga_out_t out_q;
  vga_out_t out_d;
  logic     h_last;
  logic     v_last;

  always_comb begin
    h_last = (hc_q == cnt_t'(HTOT - 1));
    v_last = (vc_q == cnt_t'(VTOT - 1));

    hc_d = h_last ? '0 : hc_q + 1'b1;
    vc_d = vc_q;
    if (h_last) begin
      vc_d = v_last ? '0 : vc_q + 1'b1;
    end

    // Every output field decodes the same counter snapshot, so they stay skew-free.
    out_d.x_px        = hc_q;
    out_d.y_px        = vc_q;
    out_d.activevideo = (hc_q < cnt_t'(activeHvideo)) && (vc_q < cnt_t'(activeVvideo));
    out_d.hsync       = in_window(hc_q, cnt_t'(HS_START), cnt_t'(HS_START + hpulse))
                        ? SYNC_ACT : SYNC_IDLE;
    out_d.vsync       = in_window(vc_q, cnt_t'(VS_START), cnt_t'(VS_START + vpulse))
                        ? SYNC_ACT : SYNC_IDLE;
  end

  always_ff @(posedge px_clk) begin
    if (rst_i) begin
      hc_q              <= '0;
      vc_q              <= '0;
      out_q.x_px        <= '0;
      out_q.y_px        <= '0;
      out_q.activevideo <= 1'b0;
      out_q.hsync       <= SYNC_IDLE;
      out_q.vsync       <= SYNC_IDLE;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      out_q <= out_d;
    end
  end

  assign vga.hsync       = out_q.hsync;
  assign vga.vsync       = out_q.vsync;
  assign vga.x_px        = out_q.x_px;
  assign vga.y_px        = out_q.y_px;
  assign vga.activevideo = out_q.activevideo;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Four timing configurations share one clock and reset; expected beam state comes from a cycle-count model.
module tb_vga_sync_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
  } obs_t;

  typedef obs_t [3:0] obs4_t;

  localparam int NCYC = 20000;
  localparam int MID_RESET_POS = 3 * 832 + 300;

  // Per-instance timing: 0 default, 1 small, 2 small with positive sync, 3 default H with small V.
  int    AH  [4] = '{640, 8, 8, 640};
  int    HFP [4] = '{24,  1, 1, 24};
  int    HP  [4] = '{40,  2, 2, 40};
  int    HBP [4] = '{128, 1, 1, 128};
  int    AV  [4] = '{480, 4, 4, 4};
  int    VFP [4] = '{9,   1, 1, 1};
  int    VP  [4] = '{2,   1, 1, 1};
  int    VBP [4] = '{29,  1, 1, 1};
  bit    POL [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  string NAME[4] = '{"def", "small", "pol", "mid"};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic px_clk0, px_clk1, px_clk2, px_clk3;

  int checks = 0;
  int fails  = 0;
  bit done   = 1'b0;

  obs4_t exp_q[$];

  always #5 clk = ~clk;

  vga_sync_gen_if if_def ();
  vga_sync_gen_if if_small ();
  vga_sync_gen_if if_pol ();
  vga_sync_gen_if if_mid ();

  vga_sync_gen #(.SIM_BYPASS(1'b1)) dut_def (
    .clk(clk), .reset(reset), .px_clk(px_clk0), .vga(if_def)
  );

  vga_sync_gen #(
    .activeHvideo(8), .hfp(1), .hpulse(2), .hbp(1),
    .activeVvideo(4), .vfp(1), .vpulse(1), .vbp(1),
    .SYNC_POL(1'b0), .SIM_BYPASS(1'b1)
  ) dut_small (
    .clk(clk), .reset(reset), .px_clk(px_clk1), .vga(if_small)
  );

  vga_sync_gen #(
    .activeHvideo(8), .hfp(1), .hpulse(2), .hbp(1),
    .activeVvideo(4), .vfp(1), .vpulse(1), .vbp(1),
    .SYNC_POL(1'b1), .SIM_BYPASS(1'b1)
  ) dut_pol (
    .clk(clk), .reset(reset), .px_clk(px_clk2), .vga(if_pol)
  );

  vga_sync_gen #(
    .activeVvideo(4), .vfp(1), .vpulse(1), .vbp(1),
    .SIM_BYPASS(1'b1)
  ) dut_mid (
    .clk(clk), .reset(reset), .px_clk(px_clk3), .vga(if_mid)
  );

  // Expected beam state after p clean cycles since reset release (p < 0: still in reset).
  function automatic obs_t model(int k, int p);
    obs_t o;
    int htot, vtot, x, y, hs0, vs0;
    if (p < 0) begin
      o.hs  = ~POL[k];
      o.vs  = ~POL[k];
      o.x   = '0;
      o.y   = '0;
      o.act = 1'b0;
      return o;
    end
    htot  = AH[k] + HFP[k] + HP[k] + HBP[k];
    vtot  = AV[k] + VFP[k] + VP[k] + VBP[k];
    x     = p % htot;
    y     = (p / htot) % vtot;
    hs0   = AH[k] + HFP[k];
    vs0   = AV[k] + VFP[k];
    o.x   = 11'(x);
    o.y   = 11'(y);
    o.act = (x < AH[k]) && (y < AV[k]);
    o.hs  = (x >= hs0 && x < hs0 + HP[k]) ? POL[k] : ~POL[k];
    o.vs  = (y >= vs0 && y < vs0 + VP[k]) ? POL[k] : ~POL[k];
    return o;
  endfunction

  // Stimulus: choose reset for the coming edge and queue what every DUT must show after it.
  initial begin
    int    pos;
    int    burst;
    bit    mid_done;
    bit    r;
    obs4_t e;
    pos      = 0;
    burst    = 0;
    mid_done = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      r = 1'b0;
      if (c < 5) begin
        r = 1'b1;
      end else if (!mid_done && pos == MID_RESET_POS) begin
        r        = 1'b1;
        mid_done = 1'b1;
      end else if (burst > 0) begin
        r     = 1'b1;
        burst = burst - 1;
      end else if (c > 12000 && $urandom_range(0, 2499) == 0) begin
        r     = 1'b1;
        burst = int'($urandom_range(0, 3));
      end
      reset = r;
      for (int k = 0; k < 4; k++) begin
        e[k] = model(k, r ? -1 : pos);
      end
      exp_q.push_back(e);
      pos = r ? 0 : pos + 1;
      @(posedge clk);
      #1;
    end
    done = 1'b1;
  end

  // Monitor: one queued expectation per clock, compared mid-cycle.
  initial begin
    obs4_t e;
    obs4_t a;
    int    cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a[0] = {if_def.hsync,   if_def.vsync,   if_def.x_px,   if_def.y_px,   if_def.activevideo};
        a[1] = {if_small.hsync, if_small.vsync, if_small.x_px, if_small.y_px, if_small.activevideo};
        a[2] = {if_pol.hsync,   if_pol.vsync,   if_pol.x_px,   if_pol.y_px,   if_pol.activevideo};
        a[3] = {if_mid.hsync,   if_mid.vsync,   if_mid.x_px,   if_mid.y_px,   if_mid.activevideo};
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (a[k] !== e[k]) begin
            fails++;
            $display("FAIL %s cycle %0d: got x=%0d y=%0d hs=%b vs=%b act=%b, want x=%0d y=%0d hs=%b vs=%b act=%b",
                     NAME[k], cyc, a[k].x, a[k].y, a[k].hs, a[k].vs, a[k].act,
                     e[k].x, e[k].y, e[k].hs, e[k].vs, e[k].act);
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    wait (done);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
